// File: rtl/sop_pkg.sv
// Shared types and helpers for the sum-of-products MAC: FSM states,
// accumulator sizing and product extension.
package sop_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Wide enough to add TERMS full-width products without wrapping.
  function automatic int acc_width(input int w, input int t);
    return 2 * w + $clog2(t);
  endfunction

  // Extends a pw-bit product to 64 bits: sign-extends when sgn is set,
  // zero-extends otherwise.
  function automatic logic [63:0] ext_prod(input logic [63:0] p, input int pw, input bit sgn);
    logic [63:0] r;
    r = p;
    for (int i = 0; i < 64; i++) begin
      if (i >= pw) r[i] = sgn & p[pw-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/sop_mult_stage.sv
// Registered multiplier: captures a*b at full 2*WIDTH width on load and
// flags it with prod_v for exactly one cycle.
module sop_mult_stage #(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               load,
  output logic [2*WIDTH-1:0] prod_q,
  output logic               prod_v
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] ax;
  logic [PW-1:0] bx;
  logic [PW-1:0] prod_d;

  // Extending both operands to PW first makes the truncated product
  // correct for two's-complement as well as unsigned operands.
  always_comb begin
    ax = '0;
    bx = '0;
    if (SIGNED != 0) begin
      ax = {{WIDTH{a[WIDTH-1]}}, a};
      bx = {{WIDTH{b[WIDTH-1]}}, b};
    end else begin
      ax = {{WIDTH{1'b0}}, a};
      bx = {{WIDTH{1'b0}}, b};
    end
    prod_d = ax * bx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      prod_v <= 1'b0;
    end else if (clear) begin
      prod_v <= 1'b0;
    end else begin
      prod_v <= load;
      if (load) prod_q <= prod_d;
    end
  end

endmodule

// File: rtl/sop_mac.sv
// Sequential sum-of-products engine: accepts TERMS operand pairs, multiplies
// each in a registered stage and presents one accumulated sum per batch.
module sop_mac
  import sop_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int TERMS  = 4,
  parameter  int SIGNED = 0,
  localparam int ACC_W  = acc_width(WIDTH, TERMS),
  localparam int CNT_W  = $clog2(TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic [CNT_W-1:0] term_cnt,
  output logic [1:0]       state_dbg
);

  localparam int PW = 2 * WIDTH;

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; the source holds its data until then, and ready never waits
  // on valid in the same cycle.

  state_t          state;
  logic [ACC_W-1:0] acc;
  logic [PW-1:0]   prod_q;
  logic            prod_v;
  logic [ACC_W-1:0] prod_ext;
  logic            accept;

  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid & in_ready;
  assign sum       = acc;
  assign state_dbg = state;
  assign prod_ext  = ACC_W'(ext_prod(64'(prod_q), PW, SIGNED != 0));

  sop_mult_stage #(
    .WIDTH (WIDTH),
    .SIGNED(SIGNED)
  ) u_mult (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .a     (a),
    .b     (b),
    .load  (accept),
    .prod_q(prod_q),
    .prod_v(prod_v)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= ACCUM;
      acc       <= '0;
      term_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (prod_v) acc <= acc + prod_ext;
      case (state)
        ACCUM: begin
          if (accept) begin
            term_cnt <= term_cnt + 1'b1;
            if (term_cnt == CNT_W'(TERMS - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The final product lands in acc on this same edge.
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            acc       <= '0;
            term_cnt  <= '0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sop_mac.sv
// Directed bench for sop_mac: unsigned, signed and TERMS=1 instances sharing
// one stimulus path, selected by sel.
module tb_sop_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic iv = 1'b0;
  logic ory = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  int sel = 0;

  int checks = 0;
  int errors = 0;

  logic       rdy_u, rdy_s, rdy_o;
  logic       ov_u, ov_s, ov_o;
  logic [9:0] sum_u, sum_s;
  logic [7:0] sum_o;
  logic [2:0] tc_u, tc_s;
  logic [0:0] tc_o;
  logic [1:0] st_u, st_s, st_o;

  logic       rdy_m, ov_m;
  logic [9:0] sum_m;
  logic [2:0] tc_m;
  logic [1:0] st_m;

  always #5 clk = ~clk;

  sop_mac #(.WIDTH(4), .TERMS(4), .SIGNED(0)) u_uns (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(iv && sel == 0), .in_ready(rdy_u),
    .a(a), .b(b), .out_valid(ov_u), .out_ready(ory && sel == 0), .sum(sum_u),
    .term_cnt(tc_u), .state_dbg(st_u));

  sop_mac #(.WIDTH(4), .TERMS(4), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(iv && sel == 1), .in_ready(rdy_s),
    .a(a), .b(b), .out_valid(ov_s), .out_ready(ory && sel == 1), .sum(sum_s),
    .term_cnt(tc_s), .state_dbg(st_s));

  sop_mac #(.WIDTH(4), .TERMS(1), .SIGNED(0)) u_one (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(iv && sel == 2), .in_ready(rdy_o),
    .a(a), .b(b), .out_valid(ov_o), .out_ready(ory && sel == 2), .sum(sum_o),
    .term_cnt(tc_o), .state_dbg(st_o));

  always_comb begin
    rdy_m = rdy_u; ov_m = ov_u; sum_m = sum_u; tc_m = tc_u; st_m = st_u;
    if (sel == 1) begin
      rdy_m = rdy_s; ov_m = ov_s; sum_m = sum_s; tc_m = tc_s; st_m = st_s;
    end else if (sel == 2) begin
      rdy_m = rdy_o; ov_m = ov_o; sum_m = {2'b00, sum_o}; tc_m = {2'b00, tc_o}; st_m = st_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair and returns #1 after the edge that accepted it.
  task automatic send(input logic [3:0] av, input logic [3:0] bv);
    int n = 0;
    a = av; b = bv; iv = 1'b1;
    while (!rdy_m && n < 30) begin
      tick();
      n++;
    end
    if (n >= 30) chk("send_timeout", 32'd0, 32'd1);
    tick();
    iv = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!ov_m && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 32'(ov_m), 32'd1);
  endtask

  task automatic take();
    ory = 1'b1;
    tick();
    ory = 1'b0;
  endtask

  initial begin
    int nvalid;
    // reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_sum", 32'(sum_m), 32'd0);
    chk("rst_out_valid", 32'(ov_m), 32'd0);
    chk("rst_in_ready", 32'(rdy_m), 32'd1);
    chk("rst_term_cnt", 32'(tc_m), 32'd0);
    chk("rst_state", 32'(st_m), 32'd0);

    // unsigned basic, back-to-back, latency
    send(4'd1, 4'd2); send(4'd3, 4'd4); send(4'd5, 4'd6); send(4'd7, 4'd8);
    chk("basic_drain_ov", 32'(ov_m), 32'd0);
    chk("basic_drain_rdy", 32'(rdy_m), 32'd0);
    chk("basic_drain_state", 32'(st_m), 32'd1);
    tick();
    chk("basic_latency_ov", 32'(ov_m), 32'd1);
    chk("basic_sum", 32'(sum_m), 32'd100);
    chk("basic_term_cnt", 32'(tc_m), 32'd4);
    chk("basic_state", 32'(st_m), 32'd2);
    take();
    chk("basic_rel_ov", 32'(ov_m), 32'd0);
    chk("basic_rel_rdy", 32'(rdy_m), 32'd1);
    chk("basic_rel_sum", 32'(sum_m), 32'd0);
    chk("basic_rel_cnt", 32'(tc_m), 32'd0);

    // max magnitude, then zeros
    for (int i = 0; i < 4; i++) send(4'd15, 4'd15);
    wait_valid("max_valid");
    chk("max_sum", 32'(sum_m), 32'd900);
    take();
    for (int i = 0; i < 4; i++) send(4'd0, 4'd0);
    wait_valid("zero_valid");
    chk("zero_sum", 32'(sum_m), 32'd0);
    take();

    // gaps in in_valid, then output backpressure
    send(4'd2, 4'd3); tick();
    send(4'd4, 4'd5); tick();
    send(4'd6, 4'd7); tick();
    send(4'd1, 4'd9);
    wait_valid("gap_valid");
    chk("gap_sum", 32'(sum_m), 32'd77);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_sum", 32'(sum_m), 32'd77);
      chk("hold_ov", 32'(ov_m), 32'd1);
      chk("hold_rdy", 32'(rdy_m), 32'd0);
    end
    take();
    chk("hold_rel_rdy", 32'(rdy_m), 32'd1);

    // clear after two accepts, with a product still in flight
    send(4'd9, 4'd9); send(4'd8, 4'd8);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_cnt", 32'(tc_m), 32'd0);
    chk("clr_sum", 32'(sum_m), 32'd0);
    tick();
    chk("clr_no_stale", 32'(sum_m), 32'd0);
    for (int i = 0; i < 4; i++) send(4'd1, 4'd1);
    wait_valid("clr_next_valid");
    chk("clr_next_sum", 32'(sum_m), 32'd4);
    take();

    // rst during DRAIN
    for (int i = 0; i < 4; i++) send(4'd3, 4'd3);
    chk("rstd_in_drain", 32'(st_m), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstd_sum", 32'(sum_m), 32'd0);
    chk("rstd_ov", 32'(ov_m), 32'd0);
    chk("rstd_rdy", 32'(rdy_m), 32'd1);
    chk("rstd_cnt", 32'(tc_m), 32'd0);
    tick();
    chk("rstd_no_stale", 32'(sum_m), 32'd0);
    for (int i = 0; i < 4; i++) send(4'd2, 4'd2);
    wait_valid("rstd_next_valid");
    chk("rstd_next_sum", 32'(sum_m), 32'd16);
    take();

    // signed instance
    sel = 1;
    for (int i = 0; i < 4; i++) send(4'h8, 4'h8);
    tick();
    chk("sgn_valid", 32'(ov_m), 32'd1);
    chk("sgn_pos_sum", 32'(sum_m), 32'h100);
    take();
    for (int i = 0; i < 4; i++) send(4'h8, 4'h7);
    wait_valid("sgn_neg_valid");
    chk("sgn_neg_sum", 32'(sum_m), 32'h320);
    take();

    // TERMS=1 instance
    sel = 2;
    send(4'd3, 4'd5);
    chk("one_drain_ov", 32'(ov_m), 32'd0);
    tick();
    chk("one_valid", 32'(ov_m), 32'd1);
    chk("one_sum", 32'(sum_m), 32'd15);
    take();
    chk("one_rel_rdy", 32'(rdy_m), 32'd1);

    // continuous valid/ready: one result every 3 cycles
    a = 4'd1; b = 4'd2; iv = 1'b1; ory = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (ov_m) begin
        nvalid++;
        chk("stream_sum", 32'(sum_m), 32'd2);
      end
    end
    iv = 1'b0; ory = 1'b0;
    chk("stream_count", 32'(nvalid), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
